// File: rtl/mem_access_unit.sv
`default_nettype none
//==============================================================================
// Module      : mem_access_unit
// Description : Core-side load/store unit driving a word-wide memory; sub-word
//               stores use read-modify-write. MEM_ACCESS_STATS_EN adds counters.
// Revision    : 1.0
//==============================================================================
module mem_access_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_faults
`endif
);

    localparam logic [3:0] c_lat_m1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [1:0]        r_lane, w_lane;
    logic [1:0]        r_size, w_size;
    logic              r_we, w_we;
    logic              r_unsigned, w_unsigned;
    logic [31:0]       r_wdata, w_wdata;
    logic [3:0]        r_cnt, w_cnt;
    logic              r_req_ready, w_req_ready;
    logic              r_resp_valid, w_resp_valid;
    logic [31:0]       r_resp_rdata, w_resp_rdata;
    logic              r_resp_fault, w_resp_fault;
    logic [ADDR_W-1:0] r_mem_address, w_mem_address;
    logic [31:0]       r_mem_wdata, w_mem_wdata;
    logic              r_mem_we, w_mem_we;
    logic              w_req_fault;

    assign w_req_fault = (req_size == 2'd3) ||
                         (req_size == 2'd1 && req_addr[0]) ||
                         (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'd0:    f_extract = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    f_extract = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: f_extract = word;
        endcase
    endfunction

    // Replace only the addressed lanes of the captured word with the store data.
    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'd0: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'd0, wdata[7:0]} << {lane, 3'b000};
            end
            2'd1: begin
                mask = 32'h0000_FFFF << {lane, 3'b000};
                data = {16'd0, wdata[15:0]} << {lane, 3'b000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        f_merge = (word & ~mask) | data;
    endfunction

    always_comb begin
        w_state       = r_state;
        w_lane        = r_lane;
        w_size        = r_size;
        w_we          = r_we;
        w_unsigned    = r_unsigned;
        w_wdata       = r_wdata;
        w_cnt         = r_cnt;
        w_req_ready   = r_req_ready;
        w_resp_valid  = r_resp_valid;
        w_resp_rdata  = r_resp_rdata;
        w_resp_fault  = r_resp_fault;
        w_mem_address = r_mem_address;
        w_mem_wdata   = r_mem_wdata;
        w_mem_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_lane       = req_addr[1:0];
                    w_size       = req_size;
                    w_we         = req_we;
                    w_unsigned   = req_unsigned;
                    w_wdata      = req_wdata;
                    w_req_ready  = 1'b0;
                    w_resp_rdata = 32'd0;
                    w_resp_fault = 1'b0;
                    if (w_req_fault) begin
                        // Faults go straight to the response without touching memory.
                        w_state      = S_RESP;
                        w_resp_fault = 1'b1;
                        w_resp_valid = 1'b1;
                    end else if (req_we && req_size == 2'd2) begin
                        w_state       = S_WRITE;
                        w_mem_address = {req_addr[ADDR_W-1:2], 2'b00};
                        w_mem_wdata   = req_wdata;
                        w_mem_we      = 1'b1;
                    end else begin
                        w_state       = S_READ;
                        w_mem_address = {req_addr[ADDR_W-1:2], 2'b00};
                        w_cnt         = c_lat_m1;
                    end
                end
            end
            S_READ: begin
                if (r_cnt == 4'd0) begin
                    if (r_we) begin
                        w_state     = S_WRITE;
                        w_mem_wdata = f_merge(mem_rdata, r_wdata, r_lane, r_size);
                        w_mem_we    = 1'b1;
                    end else begin
                        w_state      = S_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_rdata = f_extract(mem_rdata, r_lane, r_size, r_unsigned);
                    end
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_WRITE: begin
                w_state      = S_RESP;
                w_resp_valid = 1'b1;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state      = S_IDLE;
                    w_resp_valid = 1'b0;
                    w_req_ready  = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_lane        <= 2'd0;
            r_size        <= 2'd0;
            r_we          <= 1'b0;
            r_unsigned    <= 1'b0;
            r_wdata       <= 32'd0;
            r_cnt         <= 4'd0;
            r_req_ready   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'd0;
            r_resp_fault  <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= 32'd0;
            r_mem_we      <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_lane        <= w_lane;
            r_size        <= w_size;
            r_we          <= w_we;
            r_unsigned    <= w_unsigned;
            r_wdata       <= w_wdata;
            r_cnt         <= w_cnt;
            r_req_ready   <= w_req_ready;
            r_resp_valid  <= w_resp_valid;
            r_resp_rdata  <= w_resp_rdata;
            r_resp_fault  <= w_resp_fault;
            r_mem_address <= w_mem_address;
            r_mem_wdata   <= w_mem_wdata;
            r_mem_we      <= w_mem_we;
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_fault  = r_resp_fault;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;

`ifdef MEM_ACCESS_STATS_EN
    logic        w_resp_hs;
    logic [15:0] r_stat_loads, r_stat_stores, r_stat_faults;

    assign w_resp_hs = (r_state == S_RESP) && resp_ready;

    // Saturating counters, bumped on the response handshake only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_loads  <= 16'd0;
            r_stat_stores <= 16'd0;
            r_stat_faults <= 16'd0;
        end else if (w_resp_hs) begin
            if (r_resp_fault) begin
                if (r_stat_faults != 16'hFFFF) r_stat_faults <= r_stat_faults + 16'd1;
            end else if (r_we) begin
                if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
            end else begin
                if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
            end
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_faults = r_stat_faults;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a bench-side memory.
// Revision    : 1.0
//==============================================================================
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_faults;
`endif

    mem_access_unit #(.MEM_LATENCY(1), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we)
`ifdef MEM_ACCESS_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_address[9:2]];
    always @(posedge clock) if (mem_we) mem[mem_address[9:2]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] rdata; logic fault; int lat; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    resp_t rq[$];
    int    aq[$];
    wr_t   wq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or did not occur", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a response.
    logic        seen = 1'b0;
    logic        after_hs = 1'b0;
    int          first_cyc = 0;
    logic [31:0] hold_rdata = 32'd0;
    logic        hold_fault = 1'b0;
    always @(negedge clock) begin
        if (!reset_n) begin
            seen     = 1'b0;
            after_hs = 1'b0;
        end else begin
            check("mem_addr_align", {30'd0, mem_address[1:0]}, 32'd0);
            check("mem_addr_range", {10'd0, mem_address[31:10]}, 32'd0);
            if (after_hs) begin
                check("idle_after_resp", {31'd0, req_ready}, 32'd1);
                after_hs = 1'b0;
            end
            if (mem_we) begin
                if (wq.size() == 0) fail_now("unexpected_mem_we");
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("write_addr", mem_address, w.addr);
                    check("write_data", mem_wdata, w.data);
                end
            end
            if (resp_valid) begin
                check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (!seen) begin
                    seen       = 1'b1;
                    first_cyc  = cyc;
                    hold_rdata = resp_rdata;
                    hold_fault = resp_fault;
                end else begin
                    check("resp_rdata_stable", resp_rdata, hold_rdata);
                    check("resp_fault_stable", {31'd0, resp_fault}, {31'd0, hold_fault});
                end
                if (resp_ready) begin
                    if (rq.size() == 0 || aq.size() == 0) fail_now("unexpected_resp");
                    else begin
                        resp_t e;
                        int    a;
                        e = rq.pop_front();
                        a = aq.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
                        if (e.lat != 0) check("resp_latency", first_cyc - a + 1, e.lat);
                    end
                    seen     = 1'b0;
                    after_hs = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_fault,
                         input int lat, input logic has_resp);
        bit ok;
        ok = 0;
        if (has_resp) rq.push_back('{exp_rdata, exp_fault, lat});
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("req_ready_timeout");
        @(posedge clock);
        #1;
        if (has_resp) aq.push_back(cyc);
        req_valid    = 1'b0;
        req_we       = $urandom_range(0, 1) == 1;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1) == 1;
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rq.size() == 0 && req_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("response_timeout");
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved_addr;
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'h8899AABB;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Loads
        issue(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, 32'hFFFFFFAA, 1'b0, 2, 1'b1); wait_done();
        check("load_addr", mem_address, 32'h100);
        issue(1'b0, 2'd0, 1'b1, 32'h101, 32'd0, 32'h000000AA, 1'b0, 2, 1'b1); wait_done();
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 32'hFFFF8899, 1'b0, 2, 1'b1); wait_done();
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b1); wait_done();

        // Sub-word stores (read-modify-write)
        wq.push_back('{32'h100, 32'h7799AABB});
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h12345677, 32'd0, 1'b0, 3, 1'b1); wait_done();
        wq.push_back('{32'h100, 32'h7799CAFE});
        issue(1'b1, 2'd1, 1'b0, 32'h100, 32'h0000CAFE, 32'd0, 1'b0, 3, 1'b1); wait_done();
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'h7799CAFE, 1'b0, 2, 1'b1); wait_done();

        // Faults: no memory activity, address untouched
        saved_addr = mem_address;
        issue(1'b0, 2'd2, 1'b0, 32'h106, 32'd0, 32'd0, 1'b1, 1, 1'b1); wait_done();
        issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h5555, 32'd0, 1'b1, 1, 1'b1); wait_done();
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 32'd0, 1'b1, 1, 1'b1); wait_done();
        check("fault_no_access", mem_address, saved_addr);
        check("fault_mem_intact", mem[8'h40], 32'h7799CAFE);
`ifdef MEM_ACCESS_STATS_EN
        check("stat_faults", {16'd0, stat_faults}, 32'd3);
        check("stat_stores", {16'd0, stat_stores}, 32'd2);
        check("stat_loads", {16'd0, stat_loads}, 32'd5);
`endif

        // Response back-pressure
        resp_ready = 1'b0;
        issue(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, 32'hFFFFFFFE, 1'b0, 2, 1'b1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (resp_valid) begin ok = 1; break; end
        end
        if (!ok) fail_now("resp_valid_timeout");
        repeat (2) @(negedge clock);
        check("held_resp_valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clock); #1;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("resp_done_after_ready", {31'd0, resp_valid}, 32'd0);
        wait_done();

        // Reset during WRITE of a word store
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 0, 1'b0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_we) begin ok = 1; break; end
            @(posedge clock); #2;
        end
        if (!ok) fail_now("mem_we_timeout");
        reset_n = 1'b0;
        #1;
        check("reset_drops_we", {31'd0, mem_we}, 32'd0);
        repeat (2) @(negedge clock);
        check("reset_no_resp", {31'd0, resp_valid}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clock); #1;
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'h7799CAFE, 1'b0, 2, 1'b1); wait_done();

        repeat (3) @(negedge clock);
        if (rq.size() != 0 || wq.size() != 0) fail_now("pending_expectations");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
